// File: rtl/uio_arb_pkg.sv
// Shared types and width helpers for the uio pad-bus arbiter.
package uio_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_OWN  = 2'd2
    } arb_state_t;

    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;

    // Index/counter width that stays legal (>=1 bit) when n collapses to 1.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first requester at or after i_ptr wins.
module rr_pick
    import uio_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_win,
    output logic [IW-1:0]   o_idx,
    output logic            o_vld
);

    logic [IW-1:0] w_cand;

    // Walk from the far end back toward i_ptr so the nearest hit overwrites the rest.
    always_comb begin
        o_win  = '0;
        o_idx  = '0;
        o_vld  = 1'b0;
        w_cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_cand = IW'((int'(i_ptr) + k) % NREQ);
            if (i_req[w_cand]) begin
                o_win = NREQ'(1) << w_cand;
                o_idx = w_cand;
                o_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the uio pad bus: latched direction, turnaround gap and hold watchdog.
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int         NREQ     = 4,
    parameter int         TURN_CYC = 1,
    parameter int         MAX_HOLD = 16,
    parameter logic [7:0] OE_MASK  = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   dir,
    input  logic [NREQ*8-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [7:0]        rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              timeout,
    input  logic [7:0]        uio_in,
    output logic [7:0]        uio_out,
    output logic [7:0]        uio_oe
);

    localparam int            IW        = idx_w(NREQ);
    localparam int            HW        = idx_w(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [1:0]    TURN_LAST = 2'(TURN_CYC - 1);

    arb_state_t      r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_win;
    logic            r_odir;
    logic            r_cur_dir;
    logic [HW-1:0]   r_hold_cnt;
    logic [1:0]      r_turn_cnt;
    logic [NREQ-1:0] r_gnt;
    logic [7:0]      r_rdata;
    logic            r_rvalid;
    logic            r_busy;
    logic            r_timeout;
    logic [7:0]      r_uio_out;
    logic [7:0]      r_uio_oe;

    logic [NREQ-1:0] w_pick_win;
    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_vld;
    logic [IW-1:0]   w_ptr_next;
    logic [7:0]      w_owner_wdata;
    logic            w_owner_req;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_win (w_pick_win),
        .o_idx (w_pick_idx),
        .o_vld (w_pick_vld)
    );

    // The just-served owner drops to lowest priority for the next arbitration.
    assign w_ptr_next    = (r_win == IW'(NREQ - 1)) ? '0 : r_win + 1'b1;
    assign w_owner_wdata = wdata[8*r_win +: 8];
    assign w_owner_req   = req[r_win];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_win      <= '0;
            r_odir     <= DIR_IN;
            r_cur_dir  <= DIR_IN;
            r_hold_cnt <= '0;
            r_turn_cnt <= '0;
            r_gnt      <= '0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_uio_out  <= '0;
            r_uio_oe   <= '0;
        end else begin
            r_timeout <= 1'b0;
            r_rvalid  <= 1'b0;
            if (!ena) begin
                r_state    <= ST_IDLE;
                r_busy     <= 1'b0;
                r_gnt      <= '0;
                r_uio_oe   <= '0;
                r_cur_dir  <= DIR_IN;
                r_hold_cnt <= '0;
                r_turn_cnt <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_pick_vld) begin
                            r_win  <= w_pick_idx;
                            r_odir <= dir[w_pick_idx];
                            r_busy <= 1'b1;
                            if (dir[w_pick_idx] == r_cur_dir) begin
                                r_state <= ST_OWN;
                                r_gnt   <= w_pick_win;
                            end else begin
                                r_state    <= ST_TURN;
                                r_turn_cnt <= '0;
                                r_uio_oe   <= '0;
                            end
                        end
                    end
                    ST_TURN: begin
                        if (r_turn_cnt == TURN_LAST) begin
                            r_state   <= ST_OWN;
                            r_cur_dir <= r_odir;
                            r_gnt     <= NREQ'(1) << r_win;
                        end else begin
                            r_turn_cnt <= r_turn_cnt + 2'd1;
                        end
                    end
                    ST_OWN: begin
                        if (r_cur_dir == DIR_OUT) begin
                            r_uio_oe  <= OE_MASK;
                            r_uio_out <= w_owner_wdata;
                        end else begin
                            r_uio_oe <= '0;
                            r_rdata  <= uio_in;
                            r_rvalid <= 1'b1;
                        end
                        // A voluntary release takes precedence over the watchdog.
                        if (!w_owner_req || (r_hold_cnt == HOLD_LAST)) begin
                            r_state    <= ST_IDLE;
                            r_busy     <= 1'b0;
                            r_gnt      <= '0;
                            r_ptr      <= w_ptr_next;
                            r_hold_cnt <= '0;
                            r_timeout  <= w_owner_req;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_gnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign gnt     = r_gnt;
    assign rdata   = r_rdata;
    assign rvalid  = r_rvalid;
    assign busy    = r_busy;
    assign timeout = r_timeout;
    assign uio_out = r_uio_out;
    assign uio_oe  = r_uio_oe;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Scoreboard bench for uio_bus_arbiter: directed vectors push expected grants, pad values, read beats and timeouts.
module tb_uio_bus_arbiter;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        ena    = 1'b0;
    logic [3:0]  req    = '0;
    logic [3:0]  dir    = '0;
    logic [31:0] wdata  = '0;
    logic [7:0]  uio_in = '0;
    logic [3:0]  gnt;
    logic [7:0]  rdata;
    logic        rvalid;
    logic        busy;
    logic        timeout;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int         cyc;
        logic [3:0] gnt;
        logic [7:0] oe;
    } gs_t;

    gs_t         q_gs[$];
    int          q_len[$];
    logic [15:0] q_pad[$];
    logic [7:0]  q_rd[$];
    int          q_to[$];

    uio_bus_arbiter #(
        .NREQ     (4),
        .TURN_CYC (1),
        .MAX_HOLD (16),
        .OE_MASK  (8'hFF)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .req     (req),
        .dir     (dir),
        .wdata   (wdata),
        .gnt     (gnt),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .busy    (busy),
        .timeout (timeout),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic unexpected(input string name);
        n_chk++;
        $display("FAIL %s: unexpected event, nothing queued (cycle %0d)", name, cyc);
    endtask

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_grant(input int c, input int idx, input logic [7:0] oe, input int len,
                             input logic [15:0] pad);
        gs_t g;
        g.cyc = c;
        g.gnt = 4'(1 << idx);
        g.oe  = oe;
        q_gs.push_back(g);
        q_len.push_back(len);
        q_pad.push_back(pad);
    endtask

    task automatic exp_rd(input int n, input logic [7:0] v);
        repeat (n) q_rd.push_back(v);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        ena    = 1'b1;
        req    = '0;
        dir    = '0;
        wdata  = '0;
        uio_in = '0;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_oe", uio_oe, 0);
        chk("rst_out", uio_out, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    initial begin
        logic [3:0]  prev_gnt;
        int          glen;
        bit          pad_due;
        gs_t         g;
        logic [15:0] p;
        prev_gnt = '0;
        glen     = 0;
        pad_due  = 1'b0;
        forever begin
            @(negedge clk);
            if (pad_due) begin
                pad_due = 1'b0;
                if (q_pad.size() == 0) unexpected("pad");
                else begin
                    p = q_pad.pop_front();
                    chk("pad_oe", uio_oe, p[15:8]);
                    chk("pad_out", uio_out, p[7:0]);
                end
            end
            if (gnt != 0 && prev_gnt == 0) begin
                if (q_gs.size() == 0) unexpected("grant");
                else begin
                    g = q_gs.pop_front();
                    chk("gnt_val", gnt, g.gnt);
                    chk("gnt_cycle", cyc, g.cyc);
                    chk("gnt_start_oe", uio_oe, g.oe);
                end
                glen    = 1;
                pad_due = 1'b1;
            end else if (gnt != 0) begin
                glen++;
            end
            if (gnt == 0 && prev_gnt != 0) begin
                if (q_len.size() == 0) unexpected("gnt_len");
                else chk("gnt_len", glen, q_len.pop_front());
            end
            if (rvalid === 1'b1) begin
                if (q_rd.size() == 0) unexpected("rdata");
                else chk("rdata", rdata, q_rd.pop_front());
            end
            if (timeout === 1'b1) begin
                if (q_to.size() == 0) unexpected("timeout");
                else chk("timeout_cycle", cyc, q_to.pop_front());
            end
            prev_gnt = gnt;
        end
    end

    initial begin
        int k;
        #2;

        // 1: single OUT requester after reset goes through a turnaround
        do_reset();
        k = cyc;
        dir[0] = 1'b1; wdata[7:0] = 8'hA5; req[0] = 1'b1;
        exp_grant(k + 2, 0, 8'h00, 4, {8'hFF, 8'hA5});
        at(k + 3); chk("t1_busy", busy, 1);
        at(k + 5); req[0] = 1'b0;
        at(k + 7); chk("t1_park_oe", uio_oe, 8'hFF);
        at(k + 9);

        // 2: all IN requesters, rotation 0,1,2,3,0 with one idle cycle between grants
        do_reset();
        uio_in = 8'h96;
        k = cyc;
        req = 4'hF;
        for (int i = 0; i < 4; i++) exp_grant(k + 1 + 4*i, i, 8'h00, 3, {8'h00, 8'h00});
        exp_grant(k + 17, 0, 8'h00, 3, {8'h00, 8'h00});
        exp_rd(15, 8'h96);
        at(k + 3);  req[0] = 1'b0;
        at(k + 5);  req[0] = 1'b1;
        at(k + 7);  req[1] = 1'b0;
        at(k + 11); req[2] = 1'b0;
        at(k + 15); req[3] = 1'b0;
        at(k + 19); req[0] = 1'b0;
        at(k + 23);

        // 3: OUT owner hands over to IN owner through a turnaround
        do_reset();
        uio_in = 8'h3C;
        k = cyc;
        dir = 4'b0010; wdata[15:8] = 8'h5A; req = 4'b0110;
        exp_grant(k + 2, 1, 8'h00, 3, {8'hFF, 8'h5A});
        exp_grant(k + 7, 2, 8'h00, 4, {8'h00, 8'h5A});
        exp_rd(4, 8'h3C);
        at(k + 4);  req[1] = 1'b0;
        at(k + 5);  chk("t3_idle_oe", uio_oe, 8'hFF);
        at(k + 6);  chk("t3_turn_oe", uio_oe, 8'h00);
                    chk("t3_turn_gnt", gnt, 0);
        at(k + 10); req[2] = 1'b0;
        at(k + 14);

        // 4: watchdog forces release, next requester granted, timed-out one re-competes
        do_reset();
        uio_in = 8'h77;
        k = cyc;
        req = 4'b1100;
        exp_grant(k + 1, 2, 8'h00, 16, {8'h00, 8'h00});
        q_to.push_back(k + 17);
        exp_grant(k + 18, 3, 8'h00, 2, {8'h00, 8'h00});
        exp_grant(k + 21, 2, 8'h00, 2, {8'h00, 8'h00});
        exp_rd(20, 8'h77);
        at(k + 19); req[3] = 1'b0;
        at(k + 22); req[2] = 1'b0;
        at(k + 26);

        // 5: ena dropped mid-OWN parks the bus as input; re-enable turns around from IN
        do_reset();
        k = cyc;
        dir[0] = 1'b1; wdata[7:0] = 8'h81; req[0] = 1'b1;
        exp_grant(k + 2, 0, 8'h00, 3, {8'hFF, 8'h81});
        exp_grant(k + 8, 0, 8'h00, 2, {8'hFF, 8'h81});
        at(k + 4); ena = 1'b0;
        at(k + 5); chk("t5_gnt", gnt, 0);
                   chk("t5_oe", uio_oe, 8'h00);
                   chk("t5_busy", busy, 0);
                   chk("t5_timeout", timeout, 0);
        at(k + 6); ena = 1'b1;
        at(k + 9); req[0] = 1'b0;
        at(k + 13);

        // 6: async reset between edges mid-OWN; pointer restarts at 0
        do_reset();
        uio_in = 8'h11;
        k = cyc;
        req[1] = 1'b1;
        exp_grant(k + 1, 1, 8'h00, 2, {8'h00, 8'h00});
        exp_rd(2, 8'h11);
        at(k + 2); req[1] = 1'b0;
        at(k + 3); dir[3] = 1'b1; wdata[31:24] = 8'h42; req[3] = 1'b1;
        exp_grant(k + 5, 3, 8'h00, 2, {8'hFF, 8'h42});
        at(k + 7);
        #2; rst_n = 1'b0;
        #1;
        chk("t6_async_gnt", gnt, 0);
        chk("t6_async_oe", uio_oe, 8'h00);
        chk("t6_async_out", uio_out, 8'h00);
        chk("t6_async_busy", busy, 0);
        at(k + 8); rst_n = 1'b1; dir = '0; req = 4'b0101;
        exp_grant(k + 9, 0, 8'h00, 2, {8'h00, 8'h00});
        exp_grant(k + 12, 2, 8'h00, 2, {8'h00, 8'h00});
        exp_rd(4, 8'h11);
        at(k + 10); req[0] = 1'b0;
        at(k + 13); req[2] = 1'b0;
        at(k + 17);

        chk("left_grants", q_gs.size(), 0);
        chk("left_lengths", q_len.size(), 0);
        chk("left_pads", q_pad.size(), 0);
        chk("left_rdata", q_rd.size(), 0);
        chk("left_timeouts", q_to.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
